// File: rtl/ir_seq_pkg.sv
// ir_pkg: shared definitions for the instruction register slice.
//   ir_state_t   - fill sequencer states (IDLE, FILL, HOLD)
//   IR_DATA_W    - default slot / MDR bus width
//   IR_NUM_SLOTS - default number of slots per instruction
package ir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } ir_state_t;

    localparam int unsigned IR_DATA_W    = 8;
    localparam int unsigned IR_NUM_SLOTS = 2;

endpackage

// File: rtl/ir_seq_if.sv
// ir_seq_if: MDR-side and decoder-side signals of the instruction register.
//   master - the environment (MDR, strobes, decoder ack); drives mdr, mdr_valid,
//            auto_mode, load_sel, ir_ack and observes the register outputs.
//   slave  - ir_seq itself.
// Optional macro IR_SHADOW_EN adds ir_prev (last acknowledged instruction).
interface ir_seq_if
    import ir_pkg::*;
#(
    parameter int unsigned DATA_W    = IR_DATA_W,
    parameter int unsigned NUM_SLOTS = IR_NUM_SLOTS,
    parameter int unsigned IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
);
    logic [DATA_W-1:0]           mdr;
    logic                        mdr_valid;
    logic                        mdr_ready;
    logic                        auto_mode;
    logic [NUM_SLOTS-1:0]        load_sel;
    logic                        ir_ack;
    logic [NUM_SLOTS*DATA_W-1:0] ir_out;
    logic                        ir_valid;
    logic [IDX_W-1:0]            slot_idx;
`ifdef IR_SHADOW_EN
    logic [NUM_SLOTS*DATA_W-1:0] ir_prev;
`endif

    modport master (
        output mdr, mdr_valid, auto_mode, load_sel, ir_ack,
`ifdef IR_SHADOW_EN
        input  ir_prev,
`endif
        input  mdr_ready, ir_out, ir_valid, slot_idx
    );

    modport slave (
        input  mdr, mdr_valid, auto_mode, load_sel, ir_ack,
`ifdef IR_SHADOW_EN
        output ir_prev,
`endif
        output mdr_ready, ir_out, ir_valid, slot_idx
    );

endinterface

// File: rtl/ir_seq_slot.sv
// ir_slot: one instruction slot register.
//   clk, reset (sync, active-high), en (load enable), d (data in), q (slot value).
module ir_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/ir_seq.sv
// ir_seq: parametrised instruction register between the MDR and the decoder.
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - ir_seq_if slave: mdr/mdr_valid/mdr_ready fill handshake, auto_mode,
//           manual load_sel strobes, ir_out/ir_valid/ir_ack decoder handshake,
//           slot_idx (next slot auto fill writes).
// Manual mode: load_sel[i] captures mdr into slot i; sequencer forced to IDLE.
// Auto mode: slots filled in order on mdr handshakes, then held (HOLD) with
// ir_valid until ir_ack.
// Optional macro IR_SHADOW_EN: ir_prev captures ir_out on each accepted ack.
module ir_seq
    import ir_pkg::*;
#(
    parameter int unsigned DATA_W    = IR_DATA_W,
    parameter int unsigned NUM_SLOTS = IR_NUM_SLOTS,
    parameter int unsigned IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic    clk,
    input  logic    reset,
    ir_seq_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    ir_state_t                   state;
    logic [IDX_W-1:0]            idx;
    logic                        xfer;
    logic                        ack_taken;
    logic [NUM_SLOTS-1:0]        slot_en;
    logic [NUM_SLOTS*DATA_W-1:0] ir_word;

    assign bus.mdr_ready = bus.auto_mode && (state != HOLD);
    assign xfer          = bus.mdr_valid && bus.mdr_ready;
    // An ack in HOLD wins over a same-cycle mdr_valid because mdr_ready is low in HOLD.
    assign ack_taken     = bus.auto_mode && (state == HOLD) && bus.ir_ack;

    assign bus.ir_valid  = (state == HOLD);
    assign bus.slot_idx  = idx;
    assign bus.ir_out    = ir_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else if (!bus.auto_mode) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE, FILL: begin
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= HOLD;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= FILL;
                        end
                    end
                end
                HOLD: begin
                    if (ack_taken)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        slot_en = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (bus.auto_mode)
                slot_en[i] = xfer && (idx == IDX_W'(i));
            else
                slot_en[i] = bus.load_sel[i];
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        ir_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk   (clk),
            .reset (reset),
            .en    (slot_en[g]),
            .d     (bus.mdr),
            .q     (ir_word[g*DATA_W +: DATA_W])
        );
    end

`ifdef IR_SHADOW_EN
    logic [NUM_SLOTS*DATA_W-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (reset)
            prev_q <= '0;
        else if (ack_taken)
            prev_q <= ir_word;
    end

    assign bus.ir_prev = prev_q;
`endif

endmodule

// File: tb/tb_ir_seq.sv
// tb_ir_seq: directed self-checking bench for ir_seq.
// u2: NUM_SLOTS=2 (manual loads, auto fill, hold, ack, abort, reset).
// u4: NUM_SLOTS=4 (auto fill; ir_prev checks when IR_SHADOW_EN is defined).
module tb_ir_seq;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ir_seq_if #(.DATA_W(8), .NUM_SLOTS(2)) b2 ();
    ir_seq_if #(.DATA_W(8), .NUM_SLOTS(4)) b4 ();

    ir_seq #(.DATA_W(8), .NUM_SLOTS(2)) u2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    ir_seq #(.DATA_W(8), .NUM_SLOTS(4)) u4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        b2.mdr       = '0;
        b2.mdr_valid = 1'b0;
        b2.auto_mode = 1'b0;
        b2.load_sel  = '0;
        b2.ir_ack    = 1'b0;
        b4.mdr       = '0;
        b4.mdr_valid = 1'b0;
        b4.auto_mode = 1'b0;
        b4.load_sel  = '0;
        b4.ir_ack    = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        chk("rst_out",   64'(b2.ir_out),    64'h0);
        chk("rst_valid", 64'(b2.ir_valid),  64'h0);
        chk("rst_idx",   64'(b2.slot_idx),  64'h0);
        chk("rst_rdy_m", 64'(b2.mdr_ready), 64'h0);
        b2.auto_mode = 1'b1;
        #1;
        chk("rst_rdy_a", 64'(b2.mdr_ready), 64'h1);
        b2.auto_mode = 1'b0;
`ifdef IR_SHADOW_EN
        chk("rst_prev", 64'(b4.ir_prev), 64'h0);
`endif

        // manual loads
        b2.load_sel = 2'b01; b2.mdr = 8'h3C; tick();
        chk("man_lo",    64'(b2.ir_out),   64'h003C);
        b2.load_sel = 2'b10; b2.mdr = 8'hA5; tick();
        chk("man_hi",    64'(b2.ir_out),   64'hA53C);
        chk("man_valid", 64'(b2.ir_valid), 64'h0);
        b2.load_sel = 2'b11; b2.mdr = 8'h7E; tick();
        chk("man_both",  64'(b2.ir_out),   64'h7E7E);
        b2.load_sel = 2'b00;

        // auto fill 12, 34
        b2.auto_mode = 1'b1; b2.mdr_valid = 1'b1; b2.mdr = 8'h12;
        #1;
        chk("af_rdy0", 64'(b2.mdr_ready), 64'h1);
        chk("af_idx0", 64'(b2.slot_idx),  64'h0);
        tick();
        chk("af_idx1", 64'(b2.slot_idx),  64'h1);
        chk("af_out1", 64'(b2.ir_out),    64'h7E12);
        chk("af_val1", 64'(b2.ir_valid),  64'h0);
        b2.mdr = 8'h34; tick();
        chk("af_out2", 64'(b2.ir_out),    64'h3412);
        chk("af_val2", 64'(b2.ir_valid),  64'h1);
        chk("af_idx2", 64'(b2.slot_idx),  64'h0);
        chk("af_rdy2", 64'(b2.mdr_ready), 64'h0);

        // hold without ack; mdr_valid stays high with other data
        b2.mdr = 8'h56;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_out", 64'(b2.ir_out),   64'h3412);
            chk("hold_val", 64'(b2.ir_valid), 64'h1);
        end

        // ack together with mdr_valid: ack wins, FF waits a cycle
        b2.ir_ack = 1'b1; b2.mdr = 8'hFF; tick();
        chk("ack_val", 64'(b2.ir_valid), 64'h0);
        chk("ack_out", 64'(b2.ir_out),   64'h3412);
        chk("ack_idx", 64'(b2.slot_idx), 64'h0);
        chk("ack_rdy", 64'(b2.mdr_ready), 64'h1);
        b2.ir_ack = 1'b0; tick();
        chk("ff_out", 64'(b2.ir_out),   64'h34FF);
        chk("ff_idx", 64'(b2.slot_idx), 64'h1);
        b2.mdr_valid = 1'b0;

        // mid-fill abort
        b2.auto_mode = 1'b0; tick();
        chk("ab_idx", 64'(b2.slot_idx),  64'h0);
        chk("ab_val", 64'(b2.ir_valid),  64'h0);
        chk("ab_rdy", 64'(b2.mdr_ready), 64'h0);
        chk("ab_out", 64'(b2.ir_out),    64'h34FF);
        b2.auto_mode = 1'b1; b2.mdr_valid = 1'b1; b2.mdr = 8'hAA; tick();
        chk("ab_refill", 64'(b2.ir_out), 64'h34AA);
        b2.mdr = 8'hBB; tick();
        chk("ab_full",   64'(b2.ir_out),   64'hBBAA);
        chk("ab_hold",   64'(b2.ir_valid), 64'h1);

        // reset while in HOLD
        b2.mdr_valid = 1'b0;
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("hr_out", 64'(b2.ir_out),    64'h0);
        chk("hr_val", 64'(b2.ir_valid),  64'h0);
        chk("hr_idx", 64'(b2.slot_idx),  64'h0);
        chk("hr_rdy", 64'(b2.mdr_ready), 64'h1);
        b2.auto_mode = 1'b0;

        // four-slot instance
        b4.auto_mode = 1'b1; b4.mdr_valid = 1'b1;
        b4.mdr = 8'h11; tick();
        chk("q_idx1", 64'(b4.slot_idx), 64'h1);
        b4.mdr = 8'h22; tick();
        chk("q_idx2", 64'(b4.slot_idx), 64'h2);
        b4.mdr = 8'h33; tick();
        chk("q_idx3", 64'(b4.slot_idx), 64'h3);
        chk("q_val3", 64'(b4.ir_valid), 64'h0);
        b4.mdr = 8'h44; tick();
        chk("q_out",  64'(b4.ir_out),   64'h44332211);
        chk("q_val",  64'(b4.ir_valid), 64'h1);
        chk("q_idx0", 64'(b4.slot_idx), 64'h0);
        b4.mdr_valid = 1'b0; b4.ir_ack = 1'b1; tick();
        b4.ir_ack = 1'b0;
        chk("q_ackv", 64'(b4.ir_valid), 64'h0);
`ifdef IR_SHADOW_EN
        chk("q_prev1", 64'(b4.ir_prev), 64'h44332211);
`endif
        b4.mdr_valid = 1'b1;
        b4.mdr = 8'h55; tick();
        b4.mdr = 8'h66; tick();
        b4.mdr = 8'h77; tick();
        b4.mdr = 8'h88; tick();
        b4.mdr_valid = 1'b0;
        chk("q_out2", 64'(b4.ir_out),   64'h88776655);
        chk("q_val2", 64'(b4.ir_valid), 64'h1);
`ifdef IR_SHADOW_EN
        chk("q_prev2", 64'(b4.ir_prev), 64'h44332211);
        b4.ir_ack = 1'b1; tick();
        b4.ir_ack = 1'b0;
        chk("q_prev3", 64'(b4.ir_prev), 64'h88776655);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_seq.md
Name: ir_seq

Overview:
- Parametrised successor to the team's two-byte instruction register.
- Holds an instruction of NUM_SLOTS slots, each DATA_W bits wide, loaded from the memory data register (MDR) bus.
- Two load modes:
  - Manual: per-slot load strobes, same use as the earlier upper/lower load switches.
  - Auto: a fill sequencer loads slots in order on MDR handshakes, then presents the whole instruction to the decoder with a valid/ack handshake.
- Sits between the MDR and the decoder / seven-segment debug display.

Parameters:
- DATA_W, 8, width of one slot and of the MDR bus.
- NUM_SLOTS, 2, number of slots per instruction; legal range 1..8.
- IDX_W, $clog2(NUM_SLOTS) (minimum 1), width of the slot index.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- mdr, input, DATA_W: data from the MDR.
- mdr_valid, input, 1: mdr holds a byte offered for auto fill.
- mdr_ready, output, 1: auto sequencer accepts mdr this cycle.
- auto_mode, input, 1: 1 = auto fill; 0 = manual strobes.
- load_sel, input, NUM_SLOTS: manual per-slot load enables; bit i loads slot i.
- ir_ack, input, 1: decoder consumed the presented instruction.
- ir_out, output, NUM_SLOTS*DATA_W: slot i occupies bits [i*DATA_W +: DATA_W]; slot 0 is least significant.
- ir_valid, output, 1: the complete instruction is held for the decoder.
- slot_idx, output, IDX_W: next slot auto fill will write.

Behaviour:
- Reset:
  - All slots = 0, ir_valid = 0, slot_idx = 0, state = IDLE.
  - mdr_ready = 1 the cycle after reset, only if auto_mode = 1.
- Reset has priority over every other input, including mid-fill and in HOLD.
- States: IDLE, FILL, HOLD.
- mdr_ready = auto_mode && (state != HOLD), combinational.
- ir_valid = (state == HOLD), registered.
- A transfer occurs when mdr_valid && mdr_ready on a rising edge.
- Manual mode (auto_mode = 0):
  - Each slot i with load_sel[i] = 1 captures mdr on the edge.
  - Several bits set: all of those slots load the same mdr value.
  - The state machine is forced to IDLE and slot_idx to 0. The forcing takes effect on the next edge.
  - mdr_valid and ir_ack are ignored.
- Auto mode (auto_mode = 1): load_sel is ignored.
  - Transfer in IDLE or FILL: slot[slot_idx] <= mdr.
    - If slot_idx == NUM_SLOTS-1: slot_idx <= 0 and go to HOLD.
    - Otherwise: slot_idx <= slot_idx+1 and go to (or stay in) FILL.
  - IDLE with no transfer: remain in IDLE.
  - FILL with no transfer: hold slot_idx; no timeout.
  - HOLD:
    - Slots frozen; mdr_ready = 0.
    - ir_ack = 1: go to IDLE next edge; ir_valid drops the same edge.
    - ir_ack = 0: ir_out and ir_valid held indefinitely.
    - ir_ack with mdr_valid in the same cycle: ack is taken, mdr is not accepted. The first new byte can be accepted the cycle after.
  - ir_ack outside HOLD: ignored.
- Latency:
  - A completed instruction is visible on ir_out with ir_valid = 1 on the edge that accepts its last byte.
  - Minimum of NUM_SLOTS accepted cycles, plus 1 for ack, per instruction.
- NUM_SLOTS = 1: the transfer in IDLE goes directly to HOLD.
- auto_mode dropped mid-FILL or in HOLD:
  - Next edge: state = IDLE, slot_idx = 0, ir_valid = 0.
  - Slot contents are retained; any load_sel loads in that cycle still apply.
- Slots not yet rewritten in the current fill keep their old values; ir_out always shows raw slot contents.

Optional Feature:
- Macro name: IR_SHADOW_EN.
- When defined:
  - Adds output ir_prev [NUM_SLOTS*DATA_W].
  - On each accepted ir_ack in HOLD, ir_prev <= ir_out.
  - Reset value 0; unaffected by manual loads.
  - Used for debug display of the last executed instruction.
- When undefined: the port and register are absent; behaviour is otherwise identical.

Decomposition:
- Package ir_pkg:
  - state enum ir_state_t {IDLE, FILL, HOLD}.
  - Default constants IR_DATA_W = 8 and IR_NUM_SLOTS = 2.
- Sub-module ir_slot: one DATA_W register with synchronous reset and load enable, instantiated NUM_SLOTS times.
- The top level holds the fill FSM, index counter and per-slot enable mux, with enable = manual load_sel[i], or the auto transfer when slot_idx == i.

Test Plan:
- Reset then manual mode:
  - load_sel = 2'b01 with mdr = 8'h3C gives ir_out = 16'h003C.
  - Then load_sel = 2'b10 with mdr = 8'hA5 gives 16'hA53C; ir_valid stays 0.
- Manual load_sel = 2'b11 with mdr = 8'h7E gives ir_out = 16'h7E7E in one edge.
- Auto fill of 8'h12 then 8'h34 with mdr_valid held high:
  - slot_idx goes 0→1→0.
  - ir_out = 16'h3412, with ir_valid = 1 on edge 2 and mdr_ready = 0.
  - Hold 5 cycles without ack: everything stable.
- In HOLD, ir_ack = 1 together with mdr_valid = 1, mdr = 8'hFF:
  - Next edge: IDLE, ir_valid = 0, ir_out still 16'h3412.
  - FF is accepted only on the following edge.
- Mid-fill abort and reset:
  - After one auto byte (slot_idx = 1), drop auto_mode: slot_idx = 0 and IDLE next edge.
  - Separately, assert reset in HOLD: all outputs return to reset values next edge.
- NUM_SLOTS = 4 build with IR_SHADOW_EN:
  - Fill 11, 22, 33, 44 and ack: ir_prev = 32'h44332211.
  - Refill 55, 66, 77, 88: ir_out = 32'h88776655 while ir_prev is unchanged until the next ack.
